multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle control unit for the MIPS-subset datapath; replaces the single-cycle opcode decoder.
//  Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, waits on memory and iterative mul/div
//  handshakes, and drives the same datapath controls (RegDst, ALUSrc, ExtOp, MemtoReg, MemWrite,
//  RegWrite, Branch) per state. Also flags illegal opcodes and stalled handshakes, and counts retired instructions.
// PARAMETERS
//  OP_W      6     opcode width
//  OP_RTYPE  6'd0  OP_ORI 6'd4  OP_ADDI 6'd2  OP_MULI 6'd6 (opcode encodings, OP_W bits)
//  OP_DIVI   6'd1  OP_SW  6'd5  OP_LW   6'd3  OP_BEQ  6'd7 (any other value is illegal)
//  WAIT_MAX  16    max cycles to wait on any ready/done handshake before fault
//  CNT_W     32    width of retired-instruction counter
// PORTS
//  clk         in   1     rising-edge clock
//  rst         in   1     synchronous, active-high reset
//  opcode      in   OP_W  opcode from instruction register; sampled in DECODE
//  imem_ready  in   1     instruction memory data valid
//  dmem_ready  in   1     data memory access complete
//  alu_done    in   1     iterative mul/div result valid
//  pc_write    out  1     PC <- PC+4 (one-cycle pulse)
//  ir_load     out  1     latch instruction word (pulse)
//  alu_start   out  1     start iterative mul/div (pulse)
//  reg_dst, alu_src, ext_op, mem_to_reg  out 1 each  datapath selects, held for the whole instruction
//  mem_read, mem_write, reg_write, branch out 1 each  level, asserted only in the listed state
//  illegal     out  1     illegal opcode seen (pulse)
//  fault       out  1     sticky handshake-timeout flag; cleared only by rst
//  retired     out  CNT_W retired-instruction count, wraps modulo 2^CNT_W
//  state       out  3     current state encoding (debug)
// BEHAVIOUR
//  - Reset: state=FETCH, all outputs 0, counter 0, fault 0, wait counter 0. rst overrides any state mid-instruction;
//    no partial reg_write/mem_write is issued in the reset cycle.
//  - States: FETCH=0 DECODE=1 EXEC=2 MULDIV=3 MEM=4 WB=5 HALT=6.
//  - FETCH: wait for imem_ready; in that cycle ir_load=1, pc_write=1; next DECODE.
//  - DECODE (1 cycle): register opcode; set held selects:
//    reg_dst=Rtype; alu_src=ori|addi|muli|divi|lw|sw; ext_op=lw|sw; mem_to_reg=lw.
//    Illegal opcode: illegal=1, go FETCH, not counted as retired. Else next EXEC.
//  - EXEC (1 cycle): muli/divi -> alu_start=1, next MULDIV; lw/sw -> MEM; beq -> branch=1, retire, FETCH;
//    Rtype/ori/addi -> WB.
//  - MULDIV: wait alu_done; then WB. alu_start not re-asserted while waiting.
//  - MEM: mem_read=lw, mem_write=sw held until dmem_ready; on ready: sw retires and goes FETCH, lw goes WB.
//  - WB (1 cycle): reg_write=1, retire, next FETCH.
//  - Retire: retired increments by exactly 1 in the instruction's final cycle (beq EXEC, sw MEM-ready, WB).
//  - Wait counter: counts cycles in FETCH, MULDIV, MEM while the awaited signal is low; clears on state change.
//    When it reaches WAIT_MAX with the signal still low: fault=1, state=HALT.
//    A ready arriving in the same cycle as the limit wins; no fault.
//  - HALT: all strobes 0; held until rst.
//  - Ready asserted on the first cycle of a wait state: zero wait, no extra cycle.
//  - Latencies with ready already high: R/ori/addi 4 cycles; beq 3; sw 4; lw 5; muli/divi 4 + alu latency.
//  - Counter wrap: retired = 2^CNT_W-1, then +1 -> 0, no flag.
// TESTING
//  - Reset then addi (6'd2), all readies high -> ir_load@c0, reg_write@c3 only, alu_src=1, reg_dst=0, retired=1.
//  - lw (6'd3), dmem_ready low 3 cycles -> mem_read held 4 cycles, then reg_write, mem_to_reg=1, ext_op=1.
//  - muli (6'd6), alu_done after 5 cycles -> single alu_start pulse, WB after done, retired+1.
//  - Opcode 6'd9 -> illegal pulse in DECODE, back to FETCH, retired unchanged, no reg_write/mem_write.
//  - sw with dmem_ready stuck low for WAIT_MAX=16 cycles -> fault=1, state=6, mem_write drops. rst clears.
//    Ready on the 16th cycle instead -> no fault.
//  - rst asserted during MULDIV -> next cycle state=FETCH, all outputs 0; retired preloaded to 2^CNT_W-1 with beq -> 0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS-subset control unit: sequences FETCH/DECODE/EXEC/MULDIV/MEM/WB,
// waits on memory and mul/div handshakes with a timeout, and counts retired instructions.
module multicycle_ctrl_fsm #(
  parameter int              OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = OP_W'(0),
  parameter logic [OP_W-1:0] OP_ORI   = OP_W'(4),
  parameter logic [OP_W-1:0] OP_ADDI  = OP_W'(2),
  parameter logic [OP_W-1:0] OP_MULI  = OP_W'(6),
  parameter logic [OP_W-1:0] OP_DIVI  = OP_W'(1),
  parameter logic [OP_W-1:0] OP_SW    = OP_W'(5),
  parameter logic [OP_W-1:0] OP_LW    = OP_W'(3),
  parameter logic [OP_W-1:0] OP_BEQ   = OP_W'(7),
  parameter int              WAIT_MAX = 16,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             alu_done,
  output logic             pc_write,
  output logic             ir_load,
  output logic             alu_start,
  output logic             reg_dst,
  output logic             alu_src,
  output logic             ext_op,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic             branch,
  output logic             illegal,
  output logic             fault,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MULDIV = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  state_e            state_q,   state_d;
  logic [OP_W-1:0]   op_q,      op_d;
  logic [3:0]        sel_q,     sel_d;   // {reg_dst, alu_src, ext_op, mem_to_reg}
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              fault_q,   fault_d;
  logic [WW-1:0]     wait_q,    wait_d;
  logic              retire;
  logic              wait_low;

  function automatic logic is_legal(input logic [OP_W-1:0] op);
    case (op)
      OP_RTYPE, OP_ORI, OP_ADDI, OP_MULI,
      OP_DIVI, OP_SW, OP_LW, OP_BEQ: is_legal = 1'b1;
      default:                       is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] decode_sel(input logic [OP_W-1:0] op);
    logic rd, as, eo, mr;
    rd = (op == OP_RTYPE);
    as = (op == OP_ORI) || (op == OP_ADDI) || (op == OP_MULI) ||
         (op == OP_DIVI) || (op == OP_LW) || (op == OP_SW);
    eo = (op == OP_LW) || (op == OP_SW);
    mr = (op == OP_LW);
    decode_sel = {rd, as, eo, mr};
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sel_d     = sel_q;
    fault_d   = fault_q;
    wait_d    = '0;
    retire    = 1'b0;
    pc_write  = 1'b0;
    ir_load   = 1'b0;
    alu_start = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
    branch    = 1'b0;
    illegal   = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d  = opcode;
        sel_d = decode_sel(opcode);
        if (!is_legal(opcode)) begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (op_q == OP_MULI || op_q == OP_DIVI) begin
          alu_start = 1'b1;
          state_d   = S_MULDIV;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
        end else if (op_q == OP_BEQ) begin
          branch  = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WB;
        end
      end
      S_MULDIV: begin
        if (alu_done) state_d = S_WB;
      end
      S_MEM: begin
        mem_read  = (op_q == OP_LW);
        mem_write = (op_q == OP_SW);
        if (dmem_ready) begin
          if (op_q == OP_SW) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A ready on the limit cycle takes the normal path above, so only a still-low
    // handshake reaching the limit diverts to HALT.
    wait_low = ((state_q == S_FETCH)  && !imem_ready) ||
               ((state_q == S_MULDIV) && !alu_done)   ||
               ((state_q == S_MEM)    && !dmem_ready);
    if (wait_low) begin
      if (wait_q == WW'(WAIT_MAX - 1)) begin
        fault_d = 1'b1;
        state_d = S_HALT;
      end else begin
        wait_d = wait_q + WW'(1);
      end
    end

    retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};

    // The reset cycle must not leak a partial write or handshake strobe.
    if (rst) begin
      pc_write  = 1'b0;
      ir_load   = 1'b0;
      alu_start = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      branch    = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      sel_q     <= '0;
      retired_q <= '0;
      fault_q   <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sel_q     <= sel_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
      wait_q    <= wait_d;
    end
  end

  assign {reg_dst, alu_src, ext_op, mem_to_reg} = sel_q;
  assign retired = retired_q;
  assign fault   = fault_q;
  assign state   = state_q;

  a_mem_excl: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));
  a_fault_sticky: assert property (@(posedge clk) disable iff (rst) fault_q |=> fault_q);

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-instruction trace model built from the instruction
// rules, a scenario table, hand-written corner sequences and randomized instruction streams.
module tb_multicycle_ctrl_fsm;
  localparam int CW       = 4;
  localparam int WAIT_MAX = 16;

  logic          clk, rst;
  logic [5:0]    opcode;
  logic          imem_ready, dmem_ready, alu_done;
  logic          pc_write, ir_load, alu_start, reg_dst, alu_src, ext_op, mem_to_reg;
  logic          mem_read, mem_write, reg_write, branch, illegal, fault;
  logic [CW-1:0] retired;
  logic [2:0]    state;

  multicycle_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .alu_done(alu_done), .pc_write(pc_write), .ir_load(ir_load), .alu_start(alu_start),
    .reg_dst(reg_dst), .alu_src(alu_src), .ext_op(ext_op), .mem_to_reg(mem_to_reg),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .branch(branch),
    .illegal(illegal), .fault(fault), .retired(retired), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic pc_write, ir_load, alu_start, mem_read, mem_write, reg_write, branch, illegal;
    logic [2:0] state;
  } obs_t;

  typedef struct {
    logic [5:0] op;
    int ni, na, nd;
    int e_ir, e_rw, e_mr, e_mw, e_as, e_br, e_il, e_ret, e_busy;
    logic [3:0] e_sel;
  } vec_t;

  int vectors, miscompares;
  int c_ir, c_rw, c_mr, c_mw, c_as, c_br, c_il, c_busy;
  logic [3:0]    m_sel;
  logic [CW-1:0] m_ret;
  logic          m_fault;
  bit            halted;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h at t=%0t", nm, a, e, $time);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [5:0] rop();
    return 6'($urandom_range(0, 63));
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op <= 6'd7;
  endfunction

  function automatic logic [3:0] sel_of(input logic [5:0] op);
    logic rd, as, eo, mr;
    rd = (op == 6'd0);
    as = op inside {6'd4, 6'd2, 6'd6, 6'd1, 6'd3, 6'd5};
    eo = op inside {6'd3, 6'd5};
    mr = (op == 6'd3);
    return {rd, as, eo, mr};
  endfunction

  function automatic obs_t mk(input logic [2:0] st);
    obs_t o;
    o = '0;
    o.state = st;
    return o;
  endfunction

  // One clock: drive, compare at the falling edge, then advance past the rising edge.
  task automatic step(input logic im, input logic dm, input logic ad, input logic [5:0] op, input obs_t e);
    obs_t act;
    imem_ready = im; dmem_ready = dm; alu_done = ad; opcode = op;
    @(negedge clk);
    act = {pc_write, ir_load, alu_start, mem_read, mem_write, reg_write, branch, illegal, state};
    chk("cycle", 64'(act), 64'(e));
    chk("selects", 64'({reg_dst, alu_src, ext_op, mem_to_reg}), 64'(m_sel));
    chk("retired", 64'(retired), 64'(m_ret));
    chk("fault", 64'(fault), 64'(m_fault));
    c_ir += int'(ir_load); c_rw += int'(reg_write); c_mr += int'(mem_read);
    c_mw += int'(mem_write); c_as += int'(alu_start); c_br += int'(branch);
    c_il += int'(illegal); c_busy += int'(state != 3'd0);
    @(posedge clk); #1;
  endtask

  // which: 0 imem_ready, 1 alu_done, 2 dmem_ready; the others are don't-care noise.
  task automatic stepw(input int which, input logic v, input obs_t e);
    step(which == 0 ? v : rb(), which == 2 ? v : rb(), which == 1 ? v : rb(), rop(), e);
  endtask

  task automatic wait_phase(input int n, input int which, input obs_t e, output bit ok);
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      stepw(which, 1'b0, e);
      if (k == WAIT_MAX - 1) begin
        m_fault = 1'b1;
        halted  = 1'b1;
        ok      = 1'b0;
        return;
      end
    end
  endtask

  // Whole-instruction model: n* are low cycles before each handshake goes high.
  task automatic run_instr(input logic [5:0] op, input int ni, input int na, input int nd);
    obs_t e;
    bit ok;
    c_ir = 0; c_rw = 0; c_mr = 0; c_mw = 0; c_as = 0; c_br = 0; c_il = 0; c_busy = 0;
    e = mk(3'd0);
    wait_phase(ni, 0, e, ok);
    if (!ok) return;
    e.pc_write = 1'b1; e.ir_load = 1'b1;
    stepw(0, 1'b1, e);
    e = mk(3'd1); e.illegal = !legal(op);
    step(rb(), rb(), rb(), op, e);
    m_sel = sel_of(op);
    if (!legal(op)) return;
    e = mk(3'd2);
    if (op == 6'd6 || op == 6'd1) begin
      e.alu_start = 1'b1;
      step(rb(), rb(), rb(), rop(), e);
      e = mk(3'd3);
      wait_phase(na, 1, e, ok);
      if (!ok) return;
      stepw(1, 1'b1, e);
    end else if (op == 6'd7) begin
      e.branch = 1'b1;
      step(rb(), rb(), rb(), rop(), e);
      m_ret++;
      return;
    end else if (op == 6'd3 || op == 6'd5) begin
      step(rb(), rb(), rb(), rop(), e);
      e = mk(3'd4); e.mem_read = (op == 6'd3); e.mem_write = (op == 6'd5);
      wait_phase(nd, 2, e, ok);
      if (!ok) return;
      stepw(2, 1'b1, e);
      if (op == 6'd5) begin
        m_ret++;
        return;
      end
    end else begin
      step(rb(), rb(), rb(), rop(), e);
    end
    e = mk(3'd5); e.reg_write = 1'b1;
    step(rb(), rb(), rb(), rop(), e);
    m_ret++;
  endtask

  task automatic do_reset();
    obs_t act;
    rst = 1'b1;
    imem_ready = rb(); dmem_ready = rb(); alu_done = rb(); opcode = rop();
    @(negedge clk);
    act = {pc_write, ir_load, alu_start, mem_read, mem_write, reg_write, branch, illegal, 3'd0};
    chk("rst_strobes", 64'(act), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    m_ret = '0; m_fault = 1'b0; m_sel = '0; halted = 1'b0;
  endtask

  task automatic halt_steps(input int n);
    for (int k = 0; k < n; k++) step(rb(), rb(), rb(), rop(), mk(3'd6));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1);
  end

  vec_t tbl[12];
  logic [CW-1:0] r0;

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; opcode = '0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_done = 1'b0;
    m_ret = '0; m_fault = 1'b0; m_sel = '0; halted = 1'b0;

    //            op     ni  na  nd  ir rw mr  mw as br il ret busy sel
    tbl[0]  = '{6'd2,  0,  0,  0,  1, 1, 0,  0, 0, 0, 0, 1,  3,  4'b0100};
    tbl[1]  = '{6'd3,  0,  0,  3,  1, 1, 4,  0, 0, 0, 0, 1,  7,  4'b0111};
    tbl[2]  = '{6'd6,  0,  4,  0,  1, 1, 0,  0, 1, 0, 0, 1,  8,  4'b0100};
    tbl[3]  = '{6'd9,  0,  0,  0,  1, 0, 0,  0, 0, 0, 1, 0,  1,  4'b0000};
    tbl[4]  = '{6'd7,  0,  0,  0,  1, 0, 0,  0, 0, 1, 0, 1,  2,  4'b0000};
    tbl[5]  = '{6'd5,  0,  0,  0,  1, 0, 0,  1, 0, 0, 0, 1,  3,  4'b0110};
    tbl[6]  = '{6'd4,  2,  0,  0,  1, 1, 0,  0, 0, 0, 0, 1,  3,  4'b0100};
    tbl[7]  = '{6'd0,  0,  0,  0,  1, 1, 0,  0, 0, 0, 0, 1,  3,  4'b1000};
    tbl[8]  = '{6'd1,  1,  0,  0,  1, 1, 0,  0, 1, 0, 0, 1,  4,  4'b0100};
    tbl[9]  = '{6'd5,  0,  0, 15,  1, 0, 0, 16, 0, 0, 0, 1, 18,  4'b0110};
    tbl[10] = '{6'd3, 15,  0,  0,  1, 1, 1,  0, 0, 0, 0, 1,  4,  4'b0111};
    tbl[11] = '{6'd63, 0,  0,  0,  1, 0, 0,  0, 0, 0, 1, 0,  1,  4'b0000};

    do_reset();
    for (int i = 0; i < 12; i++) begin
      r0 = retired;
      run_instr(tbl[i].op, tbl[i].ni, tbl[i].na, tbl[i].nd);
      chk($sformatf("t%0d_ir_load", i),   64'(c_ir),   64'(tbl[i].e_ir));
      chk($sformatf("t%0d_reg_write", i), 64'(c_rw),   64'(tbl[i].e_rw));
      chk($sformatf("t%0d_mem_read", i),  64'(c_mr),   64'(tbl[i].e_mr));
      chk($sformatf("t%0d_mem_write", i), 64'(c_mw),   64'(tbl[i].e_mw));
      chk($sformatf("t%0d_alu_start", i), 64'(c_as),   64'(tbl[i].e_as));
      chk($sformatf("t%0d_branch", i),    64'(c_br),   64'(tbl[i].e_br));
      chk($sformatf("t%0d_illegal", i),   64'(c_il),   64'(tbl[i].e_il));
      chk($sformatf("t%0d_busy", i),      64'(c_busy), 64'(tbl[i].e_busy));
      chk($sformatf("t%0d_retired", i),   64'(CW'(retired - r0)), 64'(tbl[i].e_ret));
      chk($sformatf("t%0d_selects", i),
          64'({reg_dst, alu_src, ext_op, mem_to_reg}), 64'(tbl[i].e_sel));
      chk($sformatf("t%0d_fault", i),     64'(fault), 64'(0));
    end

    // sw with dmem_ready stuck low through the limit: fault, HALT, write dropped.
    run_instr(6'd5, 0, 0, 16);
    chk("to_fault", 64'(fault), 64'(1));
    chk("to_state", 64'(state), 64'(6));
    chk("to_mem_write", 64'(mem_write), 64'(0));
    halt_steps(3);
    do_reset();
    step(1'b0, rb(), rb(), rop(), mk(3'd0));

    // rst in the middle of a muli's MULDIV wait.
    begin
      obs_t e;
      e = mk(3'd0); e.pc_write = 1'b1; e.ir_load = 1'b1;
      step(1'b1, rb(), rb(), rop(), e);
      step(rb(), rb(), rb(), 6'd6, mk(3'd1));
      m_sel = sel_of(6'd6);
      e = mk(3'd2); e.alu_start = 1'b1;
      step(rb(), rb(), rb(), rop(), e);
      step(rb(), rb(), 1'b0, rop(), mk(3'd3));
      step(rb(), rb(), 1'b0, rop(), mk(3'd3));
      do_reset();
      step(1'b0, rb(), rb(), rop(), mk(3'd0));
    end

    // Counter wrap: 15 retirements to all-ones, then a beq rolls it to zero.
    do_reset();
    for (int i = 0; i < 15; i++) run_instr(6'd7, 0, 0, 0);
    chk("wrap_pre", 64'(retired), 64'(15));
    run_instr(6'd7, 0, 0, 0);
    chk("wrap", 64'(retired), 64'(0));

    // Random instruction streams, including timeouts near the limit.
    for (int i = 0; i < 250; i++) begin
      logic [5:0] op;
      int d[3];
      if (halted) begin
        halt_steps(2);
        do_reset();
      end
      op = ($urandom_range(0, 9) == 0) ? rop() : 6'($urandom_range(0, 7));
      for (int j = 0; j < 3; j++) begin
        int r;
        r = int'($urandom_range(0, 19));
        d[j] = (r < 16) ? (r % 4) : (13 + r - 16);
      end
      run_instr(op, d[0], d[1], d[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
